// File: rtl/pifo_pkg.sv
// Shared rank-pipe widths and the PIFO entry record; the rank stage imports the same widths.
package pifo_pkg;

  localparam int unsigned PIFO_RANK_WIDTH = 16;
  localparam int unsigned PIFO_META_WIDTH = 16;

  typedef struct packed {
    logic                       valid;
    logic [PIFO_RANK_WIDTH-1:0] rank;
    logic [PIFO_META_WIDTH-1:0] meta;
  } pifo_entry_t;

endpackage

// File: rtl/pifo_insert_pos.sv
// Insert-position finder: thermometer of entries ranked <= in_rank, plus its popcount.
module pifo_insert_pos
  import pifo_pkg::*;
#(
  parameter int unsigned RANK_WIDTH = PIFO_RANK_WIDTH,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned L2_DEPTH   = 4
) (
  input  logic [DEPTH-1:0]                 ent_valid,
  input  logic [DEPTH-1:0][RANK_WIDTH-1:0] ent_rank,
  input  logic [RANK_WIDTH-1:0]            in_rank,
  output logic [DEPTH-1:0]                 le_mask_c,
  output logic [L2_DEPTH:0]                pos_c
);

  localparam int unsigned CW = L2_DEPTH + 1;

  // Equal ranks count as "in front", so a new equal rank lands behind them.
  always_comb begin
    le_mask_c = '0;
    pos_c     = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      le_mask_c[i] = ent_valid[i] & (ent_rank[i] <= in_rank);
      pos_c        = pos_c + CW'(le_mask_c[i]);
    end
  end

endmodule

// File: rtl/pifo_reg_sorted.sv
// Register-based sorted PIFO: holds (rank, meta) ascending with FIFO tie-break, head at entry 0.
module pifo_reg_sorted
  import pifo_pkg::*;
#(
  parameter int unsigned RANK_WIDTH = PIFO_RANK_WIDTH,
  parameter int unsigned META_WIDTH = PIFO_META_WIDTH,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned L2_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [RANK_WIDTH-1:0] in_rank,
  input  logic [META_WIDTH-1:0] in_meta,
  output logic                  in_remove,
  input  logic                  deq_en,
  output logic                  deq_valid,
  output logic [RANK_WIDTH-1:0] deq_rank,
  output logic [META_WIDTH-1:0] deq_meta,
  output logic [L2_DEPTH:0]     count,
  output logic                  full
);

  localparam int unsigned CW = L2_DEPTH + 1;

  typedef struct packed {
    logic                  valid;
    logic [RANK_WIDTH-1:0] rank;
    logic [META_WIDTH-1:0] meta;
  } entry_t;

  entry_t [DEPTH-1:0] ent;
  entry_t [DEPTH-1:0] ent_nxt;
  logic   [CW-1:0]    count_q;
  logic   [CW-1:0]    count_nxt;
  logic               full_q;

  logic [DEPTH-1:0]                 ent_valid;
  logic [DEPTH-1:0][RANK_WIDTH-1:0] ent_rank;
  logic [DEPTH-1:0]                 le_mask;
  logic [DEPTH:0]                   le_ext;
  logic [CW-1:0]                    pos;
  logic [CW-1:0]                    ins_idx;
  logic                             deq_fire;
  logic                             ins;
  entry_t                           new_ent;

  assign deq_fire  = deq_en & ent[0].valid;
  assign in_remove = in_valid & ~rst & (~full_q | deq_fire);
  assign ins       = in_remove;
  assign new_ent   = '{valid: 1'b1, rank: in_rank, meta: in_meta};
  assign le_ext    = {1'b0, le_mask};

  // A same-cycle dequeue frees slot 0 first, pulling the insert point down by one.
  assign ins_idx = (deq_fire && pos != '0) ? pos - CW'(1) : pos;

  pifo_insert_pos #(
    .RANK_WIDTH (RANK_WIDTH),
    .DEPTH      (DEPTH),
    .L2_DEPTH   (L2_DEPTH)
  ) u_insert_pos (
    .ent_valid (ent_valid),
    .ent_rank  (ent_rank),
    .in_rank   (in_rank),
    .le_mask_c (le_mask),
    .pos_c     (pos)
  );

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_ent
    entry_t above;
    entry_t below;
    entry_t nxt;
    logic   slot;

    if (i == int'(DEPTH) - 1) begin : g_top
      assign above = '0;
    end else begin : g_mid_up
      assign above = ent[i+1];
    end
    if (i == 0) begin : g_bot
      assign below = '0;
    end else begin : g_mid_dn
      assign below = ent[i-1];
    end

    assign ent_valid[i] = ent[i].valid;
    assign ent_rank[i]  = ent[i].rank;
    assign slot         = (ins_idx == CW'(i));

    // Per-entry mux: hold, shift down (dequeue), shift up (insert), or take the new entry.
    always_comb begin
      nxt = ent[i];
      if (ins && deq_fire) begin
        if (le_ext[i+1]) nxt = above;
        else if (slot)   nxt = new_ent;
      end else if (ins) begin
        if (!le_mask[i]) nxt = slot ? new_ent : below;
      end else if (deq_fire) begin
        nxt = above;
      end
    end

    assign ent_nxt[i] = nxt;
  end

  always_comb begin
    count_nxt = count_q;
    if (ins && !deq_fire)      count_nxt = count_q + CW'(1);
    else if (deq_fire && !ins) count_nxt = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent     <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      ent     <= ent_nxt;
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
    end
  end

  assign deq_valid = ent[0].valid;
  assign deq_rank  = ent[0].rank;
  assign deq_meta  = ent[0].meta;
  assign count     = count_q;
  assign full      = full_q;

endmodule

// File: doc/pifo_reg_sorted.md
# pifo_reg_sorted

Register-based sorted PIFO that sits directly downstream of the WRR rank stage in the rank pipe. It pulls (rank, meta) pairs from the rank stage's fall-through output FIFO and holds them in ascending rank order. It presents the minimum-rank entry to the egress scheduler. Equal ranks leave in arrival order (FIFO tie-break), which preserves per-flow packet order produced by the rank stage.

## Interface
Parameters:
- RANK_WIDTH, 16, rank width; must match the rank stage.
- META_WIDTH, 16, metadata width; must match the rank stage.
- DEPTH, 16, number of entries.
- L2_DEPTH, 4, log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  rank stage has a head entry (its valid_out).
- in_rank  in  RANK_WIDTH  head rank.
- in_meta  in  META_WIDTH  head meta.
- in_remove  out  1  pop the rank-stage head this cycle (drives its remove); combinational.
- deq_en  in  1  scheduler dequeues the current head.
- deq_valid  out  1  at least one entry held.
- deq_rank  out  RANK_WIDTH  minimum rank held (entry 0).
- deq_meta  out  META_WIDTH  meta of entry 0.
- count  out  L2_DEPTH+1  entries held, 0..DEPTH.
- full  out  1  count == DEPTH.

## Operation
- Storage: DEPTH registers {valid, rank, meta}, entry 0 = head. Valid entries are contiguous from 0 and sorted ascending (non-decreasing) by rank.
- Accept: in_remove = in_valid & ~rst & (~full | (deq_en & deq_valid)). The rank stage's FIFO is fall-through, so in_rank/in_meta are captured in the same cycle in_remove is high.
- Insert position p = number of valid entries with rank <= in_rank (unsigned compare). Entries p..count-1 shift up one place. New entry is written at p. Equal ranks therefore go behind existing equals.
- Dequeue: deq_en & deq_valid → all entries shift down one place; count decrements. deq_en while empty is ignored (no state change, no error).
- Simultaneous accept + dequeue: the result equals dequeue-then-insert in one cycle. Insert index = p-1 computed against the pre-dequeue array, clamped at 0. count is unchanged. This is legal when full.
- No drops: when full and no dequeue, in_remove stays 0 and the rank stage keeps its data, and in turn asserts busy upstream.
- Outputs deq_rank/deq_meta/deq_valid/count/full are driven directly from registers.
- Ranks do not wrap: comparison is plain unsigned. Rank wrap is out of scope; the rank stage bounds it.

## Timing
- Reset (rst high at a clk edge): all valid bits 0, count 0, full 0, deq_valid 0, deq_rank 0, deq_meta 0. in_remove is forced 0 while rst is high. A reset mid-operation discards all held entries.
- Insert latency: an entry accepted at edge N is visible at the outputs after edge N (as the head if it is the minimum).
- Dequeue latency: after a deq_en edge, the next entry is on deq_rank in the following cycle. Back-to-back deq_en every cycle is supported.
- Throughput: one accept and one dequeue per cycle.
- No state machine; behaviour is a single-cycle shift-register update per cycle.

## Structure
- Shared package pifo_pkg: RANK_WIDTH, META_WIDTH defaults and the entry record {valid, rank, meta}. The rank stage imports the same widths.
- Sub-module pifo_insert_pos: combinational. DEPTH parallel comparators (valid & rank <= in_rank) giving a thermometer vector, then a popcount to p. The vector is also reused as the per-entry shift-up select mask.
- Top-level module contains the entry array, the shift/write mux per entry, the count register and the handshake logic.

## Test plan
- Reset then idle: outputs 0, deq_valid 0, in_remove 0; deq_en=1 while empty → count stays 0.
- Insert ranks 5, 2, 9, 2 (meta A, B, C, D) one per cycle, then dequeue 4 times → order 2/B, 2/D, 5/A, 9/C; count sequence 1,2,3,4 then 3,2,1,0.
- Fill 16 entries (ranks 16 down to 1); hold in_valid=1 with rank 0 → in_remove 0 and full 1. Assert deq_en → in_remove 1 that cycle; the new head is 0 next cycle and count stays 16.
- Simultaneous insert rank 3 and dequeue with contents {1, 4, 7} → contents {3, 4, 7}, head 3, count 3.
- Reset asserted with 5 entries held → next cycle count 0, deq_valid 0; in_remove 0 while rst is high even if in_valid is 1.
- Random soak: connect to the rank stage (4 flows, weights 1..3) and a random deq_en. Compare against a software sorted-list model with FIFO tie-break. Check that no entry is lost or duplicated and that count matches the model.
